// File: rtl/face_loader_pkg.sv
// Shared types and constants for the FACE instruction memory loader.
package face_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int INSTR_W = 32;
  localparam int WORD_W  = 64;

  // Kept 32 bits wide so address arithmetic stays at the bus width.
  localparam logic [31:0] BYTES_PER_WORD = 32'd8;
  localparam logic [7:0]  FULL_MASK      = 8'hFF;

endpackage

// File: rtl/instr_rom_loader.sv
// Host-side writer for the FACE instruction BRAM. Packs pairs of 32-bit
// instructions into 64-bit words (even index high, odd index low) and
// writes them at consecutive 8-byte addresses from BASE_ADDR.
module instr_rom_loader
  import face_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] PAD_INSTR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_instr,
  input  logic               s_last,
  output logic [31:0]        bram_addr,
  output logic [WORD_W-1:0]  bram_wdata,
  output logic [7:0]         bram_wmask,
  output logic               bram_wen,
  output logic               load_busy,
  output logic               load_done,
  output logic [15:0]        instr_count,
  output logic               err_overflow
);

  // One extra code point so word_idx can sit at DEPTH_WORDS once the BRAM is full.
  localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

  loader_state_t      state;
  loader_state_t      next_state;
  logic               half;
  logic [IDX_W-1:0]   word_idx;
  logic [INSTR_W-1:0] hold;
  logic               hs;
  logic               write_due;
  logic               room;
  logic [INSTR_W-1:0] write_lo;

  assign s_ready = (state == LOAD);
  assign hs      = s_valid & s_ready;
  assign room    = (word_idx != IDX_W'(DEPTH_WORDS));

  // A word is due either when the odd half of a pair is accepted or in the
  // single FLUSH cycle; a restart cancels whatever was about to be written.
  assign write_due = !load_start &&
                     (((state == LOAD) && hs && half) || (state == FLUSH));
  assign write_lo  = (state == FLUSH) ? PAD_INSTR : s_instr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; load_start restarts from any state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load_start) next_state = LOAD;
      end
      LOAD: begin
        if (load_start)       next_state = LOAD;
        else if (hs && s_last) next_state = half ? DONE : FLUSH;
      end
      FLUSH: begin
        next_state = load_start ? LOAD : DONE;
      end
      DONE: begin
        next_state = load_start ? LOAD : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Packing, addressing, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      half         <= 1'b0;
      word_idx     <= '0;
      hold         <= '0;
      instr_count  <= '0;
      err_overflow <= 1'b0;
      bram_wen     <= 1'b0;
      bram_wmask   <= 8'h00;
      bram_wdata   <= '0;
      bram_addr    <= BASE_ADDR;
      load_busy    <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      bram_wen   <= 1'b0;
      bram_wmask <= 8'h00;
      load_done  <= (state == DONE);
      load_busy  <= (next_state == LOAD) || (next_state == FLUSH);
      if (load_start) begin
        word_idx     <= '0;
        half         <= 1'b0;
        instr_count  <= '0;
        err_overflow <= 1'b0;
      end else begin
        if (hs) begin
          if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          if (!half) begin
            hold <= s_instr;
            half <= 1'b1;
          end
        end
        if (write_due) begin
          half <= 1'b0;
          if (room) begin
            bram_wen   <= 1'b1;
            bram_wmask <= FULL_MASK;
            bram_wdata <= {hold, write_lo};
            bram_addr  <= BASE_ADDR + 32'(word_idx) * BYTES_PER_WORD;
            word_idx   <= word_idx + 1'b1;
          end else begin
            err_overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule
